// File: rtl/g_regs_pkg.sv
// Shared register codes, address limit and bridge FSM encoding for the g_* register/IO block.
package g_regs_pkg;

    localparam int unsigned ADDR_W = 5;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned WIDE_W = 64;
    localparam int unsigned STATE_W = 3;
    localparam int unsigned WAIT_W = 4;

    // Register codes; even/odd pairs form the 64-bit wide-write targets.
    localparam logic [4:0] G_ADDR_00 = 5'b00000;
    localparam logic [4:0] G_ADDR_01 = 5'b00001;
    localparam logic [4:0] G_ADDR_02 = 5'b00010;
    localparam logic [4:0] G_ADDR_03 = 5'b00011;
    localparam logic [4:0] G_ADDR_04 = 5'b00100;
    localparam logic [4:0] G_ADDR_05 = 5'b00101;
    localparam logic [4:0] G_ADDR_06 = 5'b00110;
    localparam logic [4:0] G_ADDR_07 = 5'b00111;
    localparam logic [4:0] G_ADDR_08 = 5'b01000;
    localparam logic [4:0] G_ADDR_09 = 5'b01001;
    localparam logic [4:0] G_ADDR_0A = 5'b01010;
    localparam logic [4:0] G_ADDR_0B = 5'b01011;
    localparam logic [4:0] G_ADDR_0C = 5'b01100;
    localparam logic [4:0] G_ADDR_0D = 5'b01101;
    localparam logic [4:0] G_ADDR_0E = 5'b01110;
    localparam logic [4:0] G_ADDR_0F = 5'b01111;
    localparam logic [4:0] G_ADDR_10 = 5'b10000;
    localparam logic [4:0] G_ADDR_11 = 5'b10001;
    localparam logic [4:0] G_ADDR_12 = 5'b10010;
    localparam logic [4:0] G_ADDR_13 = 5'b10011;
    localparam logic [4:0] G_ADDR_14 = 5'b10100;
    localparam logic [4:0] G_ADDR_15 = 5'b10101;
    localparam logic [4:0] G_ADDR_16 = 5'b10110;
    localparam logic [4:0] G_ADDR_17 = 5'b10111;

    // Read-only codes; writes to them are harmless and still strobed.
    localparam logic [4:0] G_ADDR_RO0 = G_ADDR_09;
    localparam logic [4:0] G_ADDR_RO1 = G_ADDR_0B;

    localparam logic [4:0] LAST_ADDR = G_ADDR_17;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_CHECK  = 3'd1;
    localparam logic [2:0] ST_SETUP  = 3'd2;
    localparam logic [2:0] ST_STROBE = 3'd3;
    localparam logic [2:0] ST_HOLD   = 3'd4;
    localparam logic [2:0] ST_RESP   = 3'd5;

endpackage

// File: rtl/g_host_bridge.sv
// Serialising host-to-register-block bridge: strobed writes/reads with guaranteed setup/hold,
// plus a registered, maskable interrupt line built from the block's gwerth status.
module g_host_bridge
    import g_regs_pkg::*;
#(
    parameter int unsigned READ_WAIT = 2,
    parameter logic [4:0]  LAST_ADDR = g_regs_pkg::LAST_ADDR
) (
    input  logic        sysclk,
    input  logic        resetb,
    input  logic        host_req,
    input  logic        host_we,
    input  logic        host_wide,
    input  logic [4:0]  host_addr,
    input  logic [63:0] host_wdata,
    output logic        host_ack,
    output logic        host_err,
    output logic [31:0] host_rdata,
    output logic        host_busy,
    output logic        g_wrb,
    output logic        g_rdb,
    output logic [4:0]  g_dout_w0x0f,
    output logic [63:0] din,
    output logic        n9_bit_write,
    input  logic [31:0] g_dout,
    input  logic [31:0] gwerth,
    input  logic [31:0] irq_mask,
    output logic        g_irq
);

    logic [STATE_W-1:0] state_q, state_d;
    logic [WAIT_W-1:0]  cnt_q, cnt_d;
    logic               req_we_q, req_we_d;
    logic               req_wide_q, req_wide_d;
    logic [ADDR_W-1:0]  req_addr_q, req_addr_d;
    logic [WIDE_W-1:0]  req_wdata_q, req_wdata_d;

    logic               ack_d, err_d, busy_d, wrb_d, rdb_d, n9_d;
    logic [ADDR_W-1:0]  addr_d;
    logic [WIDE_W-1:0]  din_d;
    logic [DATA_W-1:0]  rdata_d;
    logic               req_bad_c;

    // A wide write must start on the even register of a pair.
    assign req_bad_c = (req_addr_q > LAST_ADDR) || (req_we_q && req_wide_q && req_addr_q[0]);

    // Next state and next values of every registered output.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        req_we_d    = req_we_q;
        req_wide_d  = req_wide_q;
        req_addr_d  = req_addr_q;
        req_wdata_d = req_wdata_q;
        ack_d       = 1'b0;
        err_d       = 1'b0;
        wrb_d       = 1'b1;
        rdb_d       = 1'b1;
        addr_d      = g_dout_w0x0f;
        din_d       = din;
        n9_d        = n9_bit_write;
        rdata_d     = host_rdata;

        case (state_q)
            ST_IDLE: begin
                if (host_req) begin
                    req_we_d    = host_we;
                    req_wide_d  = host_wide;
                    req_addr_d  = host_addr;
                    req_wdata_d = host_wdata;
                    state_d     = ST_CHECK;
                end
            end
            ST_CHECK: begin
                if (req_bad_c) begin
                    ack_d   = 1'b1;
                    err_d   = 1'b1;
                    state_d = ST_RESP;
                end else begin
                    addr_d  = req_addr_q;
                    din_d   = req_wdata_q;
                    n9_d    = req_we_q & req_wide_q;
                    state_d = ST_SETUP;
                end
            end
            ST_SETUP: begin
                cnt_d   = WAIT_W'(READ_WAIT - 1);
                state_d = ST_STROBE;
                if (req_we_q) begin
                    wrb_d = 1'b0;
                end else begin
                    rdb_d = 1'b0;
                end
            end
            ST_STROBE: begin
                if (req_we_q || (cnt_q == '0)) begin
                    if (!req_we_q) begin
                        rdata_d = g_dout;
                    end
                    state_d = ST_HOLD;
                end else begin
                    cnt_d = cnt_q - WAIT_W'(1);
                    rdb_d = 1'b0;
                end
            end
            ST_HOLD: begin
                ack_d   = 1'b1;
                state_d = ST_RESP;
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge sysclk or negedge resetb) begin
        if (!resetb) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            req_we_q     <= 1'b0;
            req_wide_q   <= 1'b0;
            req_addr_q   <= '0;
            req_wdata_q  <= '0;
            host_ack     <= 1'b0;
            host_err     <= 1'b0;
            host_busy    <= 1'b0;
            host_rdata   <= '0;
            g_wrb        <= 1'b1;
            g_rdb        <= 1'b1;
            g_dout_w0x0f <= '0;
            din          <= '0;
            n9_bit_write <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            req_we_q     <= req_we_d;
            req_wide_q   <= req_wide_d;
            req_addr_q   <= req_addr_d;
            req_wdata_q  <= req_wdata_d;
            host_ack     <= ack_d;
            host_err     <= err_d;
            host_busy    <= busy_d;
            host_rdata   <= rdata_d;
            g_wrb        <= wrb_d;
            g_rdb        <= rdb_d;
            g_dout_w0x0f <= addr_d;
            din          <= din_d;
            n9_bit_write <= n9_d;
        end
    end

    // Level interrupt, one cycle behind the status/mask inputs.
    always_ff @(posedge sysclk or negedge resetb) begin
        if (!resetb) begin
            g_irq <= 1'b0;
        end else begin
            g_irq <= |(gwerth & irq_mask);
        end
    end

endmodule

// File: tb/tb_g_host_bridge.sv
// Randomised self-checking bench for g_host_bridge against a transaction-level reference model.
module tb_g_host_bridge;

    localparam int unsigned RW = 2;
    localparam int unsigned MAX_CYC = 40;

    logic        sysclk = 1'b0;
    logic        resetb;
    logic        host_req, host_we, host_wide;
    logic [4:0]  host_addr;
    logic [63:0] host_wdata;
    logic        host_ack, host_err, host_busy;
    logic [31:0] host_rdata;
    logic        g_wrb, g_rdb, n9_bit_write, g_irq;
    logic [4:0]  g_dout_w0x0f;
    logic [63:0] din;
    logic [31:0] g_dout, gwerth, irq_mask;

    int passed = 0;
    int total  = 0;

    // Reference-model state: last successfully read word.
    logic [31:0] exp_rdata;

    // Observations from one transaction.
    int          obs_lat, obs_wr_low, obs_rd_low;
    logic        obs_err, obs_both_low, obs_bus_bad, obs_ack_long;
    logic [31:0] obs_rdata;

    g_host_bridge #(.READ_WAIT(RW)) dut (
        .sysclk(sysclk), .resetb(resetb),
        .host_req(host_req), .host_we(host_we), .host_wide(host_wide),
        .host_addr(host_addr), .host_wdata(host_wdata),
        .host_ack(host_ack), .host_err(host_err), .host_rdata(host_rdata), .host_busy(host_busy),
        .g_wrb(g_wrb), .g_rdb(g_rdb), .g_dout_w0x0f(g_dout_w0x0f), .din(din),
        .n9_bit_write(n9_bit_write), .g_dout(g_dout), .gwerth(gwerth),
        .irq_mask(irq_mask), .g_irq(g_irq)
    );

    always #5 sysclk = ~sysclk;

    // Expected outcome of one request, straight from the address/width rules.
    function automatic void model(input logic we, input logic wide, input logic [4:0] addr,
                                  output logic err, output int lat, output int wr, output int rd);
        err = (int'(addr) > 23) || (we && wide && addr[0]);
        lat = err ? 2 : (we ? 5 : 4 + int'(RW));
        wr  = (!err && we) ? 1 : 0;
        rd  = (!err && !we) ? int'(RW) : 0;
    endfunction

    // Issue one request; cycle 0 is the IDLE cycle in which it is accepted.
    task automatic run_txn(input logic we, input logic wide, input logic [4:0] addr,
                           input logic [63:0] wd, input logic [31:0] gd);
        logic n9x;
        n9x = we & wide;
        @(negedge sysclk);
        host_req = 1'b1; host_we = we; host_wide = wide; host_addr = addr; host_wdata = wd;
        g_dout = gd;
        @(posedge sysclk); #1;
        host_req = 1'b0; host_we = $urandom; host_wide = $urandom;
        host_addr = 5'($urandom); host_wdata = {$urandom, $urandom};
        obs_lat = 0; obs_wr_low = 0; obs_rd_low = 0; obs_err = 1'b0;
        obs_both_low = 1'b0; obs_bus_bad = 1'b0; obs_ack_long = 1'b0; obs_rdata = '0;
        for (int c = 1; c <= int'(MAX_CYC) && obs_lat == 0; c++) begin
            if (c > 1) begin
                @(posedge sysclk); #1;
            end
            if (!g_wrb) obs_wr_low++;
            if (!g_rdb) obs_rd_low++;
            if (!g_wrb && !g_rdb) obs_both_low = 1'b1;
            if (host_ack) begin
                obs_lat = c; obs_err = host_err; obs_rdata = host_rdata;
            end else if (c >= 2 && (g_dout_w0x0f !== addr || din !== wd || n9_bit_write !== n9x)) begin
                obs_bus_bad = 1'b1;
            end
        end
        @(posedge sysclk); #1;
        if (host_ack || host_busy) obs_ack_long = 1'b1;
    endtask

    // Compares one transaction's observations against the model.
    task automatic check_txn(input string name, input logic we, input logic wide,
                             input logic [4:0] addr, input logic [63:0] wd, input logic [31:0] gd);
        logic e_err; int e_lat, e_wr, e_rd;
        model(we, wide, addr, e_err, e_lat, e_wr, e_rd);
        run_txn(we, wide, addr, wd, gd);
        if (!e_err && !we) exp_rdata = gd;
        total++;
        if (obs_lat !== e_lat) $display("FAIL %s latency: got %0d want %0d", name, obs_lat, e_lat);
        else passed++;
        total++;
        if (obs_err !== e_err) $display("FAIL %s err: got %0b want %0b", name, obs_err, e_err);
        else passed++;
        total++;
        if (obs_wr_low !== e_wr || obs_rd_low !== e_rd)
            $display("FAIL %s strobes: wr %0d rd %0d want wr %0d rd %0d", name, obs_wr_low, obs_rd_low, e_wr, e_rd);
        else passed++;
        total++;
        if (obs_rdata !== exp_rdata) $display("FAIL %s rdata: got %h want %h", name, obs_rdata, exp_rdata);
        else passed++;
        total++;
        if (obs_both_low || obs_ack_long || (!e_err && obs_bus_bad))
            $display("FAIL %s bus: both_low %0b ack_long %0b bus_bad %0b want 0 0 0", name, obs_both_low, obs_ack_long, obs_bus_bad);
        else passed++;
    endtask

    task automatic test_reset();
        resetb = 1'b0; host_req = 1'b0; host_we = 1'b0; host_wide = 1'b0; host_addr = '0;
        host_wdata = '0; g_dout = '0; gwerth = '0; irq_mask = '0;
        exp_rdata = '0;
        repeat (3) @(posedge sysclk);
        #1;
        total++;
        if ({host_ack, host_err, host_busy, g_wrb, g_rdb, n9_bit_write, g_irq} !== 7'b0001100 ||
            g_dout_w0x0f !== 5'd0 || din !== 64'd0 || host_rdata !== 32'd0)
            $display("FAIL reset: flags %b addr %h din %h rdata %h want 0001100 0 0 0",
                     {host_ack, host_err, host_busy, g_wrb, g_rdb, n9_bit_write, g_irq},
                     g_dout_w0x0f, din, host_rdata);
        else passed++;
        @(negedge sysclk);
        resetb = 1'b1;
    endtask

    task automatic test_write();
        check_txn("write", 1'b1, 1'b0, 5'b00010, 64'h0000_0000_A5A5_5A5A, 32'h0);
        check_txn("write_ro", 1'b1, 1'b0, 5'b01001, {$urandom, $urandom}, 32'h0);
    endtask

    task automatic test_read();
        check_txn("read", 1'b0, 1'b0, 5'b01010, 64'h0, 32'h1234_5678);
    endtask

    task automatic test_wide();
        check_txn("wide_even", 1'b1, 1'b1, 5'b00000, 64'hFFFF_0000_0000_FFFF, 32'h0);
        check_txn("wide_odd", 1'b1, 1'b1, 5'b00001, 64'hFFFF_0000_0000_FFFF, 32'h0);
    endtask

    task automatic test_bad_read();
        check_txn("bad_read", 1'b0, 1'b0, 5'b11000, 64'h0, 32'hDEAD_BEEF);
    endtask

    task automatic test_reset_mid();
        int n;
        @(negedge sysclk);
        host_req = 1'b1; host_we = 1'b1; host_wide = 1'b0; host_addr = 5'b00011; host_wdata = 64'h55;
        @(posedge sysclk); #1;
        host_req = 1'b0;
        n = 0;
        while (g_wrb && n < 10) begin
            @(posedge sysclk); #1; n++;
        end
        total++;
        if (g_wrb !== 1'b0) $display("FAIL rst_mid strobe: g_wrb %b want 0", g_wrb);
        else passed++;
        #2 resetb = 1'b0;
        #1;
        total++;
        if (g_wrb !== 1'b1 || host_busy !== 1'b0) $display("FAIL rst_mid async: g_wrb %b busy %b want 1 0", g_wrb, host_busy);
        else passed++;
        n = 0;
        repeat (3) begin
            @(posedge sysclk); #1;
            if (host_ack) n++;
        end
        @(negedge sysclk);
        resetb = 1'b1;
        exp_rdata = '0;
        repeat (4) begin
            @(posedge sysclk); #1;
            if (host_ack) n++;
        end
        total++;
        if (n !== 0 || host_busy !== 1'b0) $display("FAIL rst_mid no_ack: acks %0d busy %b want 0 0", n, host_busy);
        else passed++;
        check_txn("after_rst", 1'b1, 1'b0, 5'b00100, {$urandom, $urandom}, 32'h0);
    endtask

    task automatic test_irq();
        logic exp;
        @(negedge sysclk); gwerth = 32'h0000_0100; irq_mask = 32'h0;
        @(posedge sysclk); #1;
        total++;
        if (g_irq !== 1'b0) $display("FAIL irq_masked: got %b want 0", g_irq); else passed++;
        @(negedge sysclk); irq_mask = 32'h0000_0100;
        @(posedge sysclk); #1;
        total++;
        if (g_irq !== 1'b1) $display("FAIL irq_enabled: got %b want 1", g_irq); else passed++;
        @(negedge sysclk); gwerth = 32'h0;
        @(posedge sysclk); #1;
        total++;
        if (g_irq !== 1'b0) $display("FAIL irq_cleared: got %b want 0", g_irq); else passed++;
        for (int i = 0; i < 12; i++) begin
            @(negedge sysclk);
            gwerth = 32'd1 << $urandom_range(31, 0);
            irq_mask = (i % 2 == 0) ? $urandom : (32'd1 << $urandom_range(31, 0));
            exp = 1'b0;
            for (int b = 0; b < 32; b++) if (gwerth[b] && irq_mask[b]) exp = 1'b1;
            @(posedge sysclk); #1;
            total++;
            if (g_irq !== exp) $display("FAIL irq_rand%0d: got %b want %b", i, g_irq, exp); else passed++;
        end
        @(negedge sysclk); gwerth = '0; irq_mask = '0;
    endtask

    task automatic test_back_to_back();
        int cyc, acks, last;
        logic bad, prev_ack;
        @(negedge sysclk);
        host_req = 1'b1; host_we = 1'b1; host_wide = 1'b0; host_addr = 5'b00110; host_wdata = {$urandom, $urandom};
        cyc = 0; acks = 0; last = 0; bad = 1'b0; prev_ack = 1'b0;
        while (acks < 3 && cyc < int'(MAX_CYC)) begin
            @(posedge sysclk); #1; cyc++;
            if (prev_ack && host_busy) bad = 1'b1;
            prev_ack = host_ack;
            if (host_ack) begin
                acks++;
                if (cyc - last != ((acks == 1) ? 5 : 6)) bad = 1'b1;
                last = cyc;
            end
        end
        @(negedge sysclk); host_req = 1'b0;
        @(posedge sysclk); #1;
        if (host_busy) bad = 1'b1;
        repeat (3) @(posedge sysclk);
        #1;
        total++;
        if (acks !== 3 || bad || host_busy) $display("FAIL b2b: acks %0d bad %b busy %b want 3 0 0", acks, bad, host_busy);
        else passed++;
    endtask

    task automatic test_random();
        for (int i = 0; i < 20; i++) begin
            check_txn($sformatf("rand%0d", i), 1'($urandom), 1'($urandom),
                      5'($urandom_range(31, 0)), {$urandom, $urandom}, $urandom);
        end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_wide();
        test_bad_read();
        test_reset_mid();
        test_irq();
        test_back_to_back();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/g_host_bridge.md
Name: g_host_bridge

Overview:
- Host-side bridge that turns single-request host transactions into the strobed register interface of the g_* register/IO block: g_wrb, g_rdb, g_dout_w0x0f, din, n9_bit_write; it captures g_dout on reads.
- Sits directly upstream of that block. It also registers the block's gwerth status vector into a maskable interrupt line for the host.
- Serialises accesses so strobe timing and address setup/hold are guaranteed by construction.

Parameters:
- READ_WAIT, 2, number of cycles g_rdb is held low; g_dout is sampled in the last one (legal range 1..15).
- LAST_ADDR, 5'b10111, highest valid register code; higher codes are rejected with an error.

Ports:
- sysclk  in  1  system clock, rising edge.
- resetb  in  1  asynchronous, active-low reset.
- host_req  in  1  request (level); accepted only in IDLE.
- host_we  in  1  1 = write, 0 = read.
- host_wide  in  1  64-bit write to the even/odd register pair; ignored for reads.
- host_addr  in  5  register code.
- host_wdata  in  64  write data; [31:0] goes to the addressed register, [63:32] to the odd partner when wide.
- host_ack  out  1  one-cycle completion pulse.
- host_err  out  1  valid with host_ack; 1 = rejected, no strobe issued.
- host_rdata  out  32  read data, valid with host_ack and held until the next ack.
- host_busy  out  1  high whenever state is not IDLE.
- g_wrb  out  1  active-low write strobe.
- g_rdb  out  1  active-low read strobe.
- g_dout_w0x0f  out  5  register code.
- din  out  64  write data.
- n9_bit_write  out  1  wide-write qualifier.
- g_dout  in  32  read data from the register block.
- gwerth  in  32  status bits from the register block.
- irq_mask  in  32  1 = bit enabled.
- g_irq  out  1  registered interrupt request.

Behaviour:
- Reset (asynchronous, resetb=0), effective immediately even mid-transaction:
  - State returns to IDLE.
  - g_wrb=1, g_rdb=1, g_dout_w0x0f=0, din=0, n9_bit_write=0.
  - host_ack=0, host_err=0, host_rdata=0, host_busy=0, g_irq=0.
  - Any interrupted transaction is lost and is never acked.
- States: IDLE, CHECK, SETUP, STROBE, HOLD, RESP.
- IDLE: if host_req=1, capture host_we, host_wide, host_addr and host_wdata, then go to CHECK. The host may change its inputs after this cycle.
- CHECK: error if addr > LAST_ADDR, or if (we & wide & addr[0]=1). On error go to RESP with err=1. Otherwise drive g_dout_w0x0f=addr, din=wdata, n9_bit_write=we&wide (0 for reads), then go to SETUP.
- SETUP: one cycle of address/data setup with both strobes high; then go to STROBE.
- STROBE:
  - Write: g_wrb=0 for exactly one cycle.
  - Read: g_rdb=0 for READ_WAIT cycles, counted by a 4-bit down-counter; host_rdata <= g_dout at the clock edge ending the last strobe cycle.
  - Then go to HOLD.
- HOLD: both strobes high; address, din and n9_bit_write unchanged; then go to RESP.
- RESP: host_ack=1 for one cycle, with host_err for this transaction; then go to IDLE.
  - g_dout_w0x0f, din and n9_bit_write keep their values in IDLE; they change only in CHECK.
- Latency from the accepting edge to the host_ack cycle:
  - Write: 5 cycles.
  - Read: 4+READ_WAIT cycles.
  - Error: 2 cycles.
- host_req still high in the cycle after RESP (back in IDLE) starts a new transaction, giving back-to-back operation. A request during busy is not queued; it is sampled again in IDLE.
- g_wrb and g_rdb are never low simultaneously.
- Strobes are never low in IDLE, CHECK, SETUP, HOLD or RESP.
- All strobe outputs are driven from flops, glitch-free.
- Writes to read-only codes (01001, 01011) are legal: normal strobe, no error.
- Interrupt:
  - g_irq <= |(gwerth & irq_mask) every cycle; one cycle of latency; level, not edge.
  - Independent of the transaction FSM.

Decomposition:
- Shared package g_regs_pkg holds:
  - The 5-bit register code constants (00000..10111).
  - LAST_ADDR.
  - The FSM state encoding.
  - The register block uses the same code constants from this package.
- No sub-module; the FSM, wait counter and interrupt flop are all inline.

Test Plan:
- Write addr 00010, data 0x0000_0000_A5A5_5A5A, wide=0:
  - g_dout_w0x0f=00010 and din stable from CHECK through HOLD.
  - g_wrb low exactly 1 cycle, n9_bit_write=0.
  - host_ack 5 cycles after accept, err=0.
- Read addr 01010, READ_WAIT=2, g_dout=0x1234_5678:
  - g_rdb low 2 cycles.
  - host_rdata=0x1234_5678 with ack 6 cycles after accept; g_wrb stays 1.
- Wide write addr 00000, data 0xFFFF_0000_0000_FFFF -> n9_bit_write=1, din carries the full 64 bits, one g_wrb pulse. Same with addr 00001 -> err=1, ack after 2 cycles, no strobe.
- Read addr 11000 -> host_err=1, host_rdata unchanged, g_rdb never low.
- Deassert resetb during the write STROBE cycle:
  - g_wrb returns to 1 asynchronously in the same cycle.
  - No ack follows.
  - After release, host_busy=0 and the next request completes normally.
- Interrupt: gwerth=0x0000_0100 with irq_mask=0 -> g_irq=0; set mask bit 8 -> g_irq=1 one cycle later; clear gwerth -> g_irq=0 one cycle later.
- Back-to-back: host_req held high for 3 writes -> 3 acks, each followed by one IDLE cycle before the next CHECK.
